// File: rtl/fuec_12_8_decoder_interface_if.sv
// Bundle of the FUEC (12,8) decoder input word and registered decode results.
// The master modport is the producer side (read path plus result consumer).
// The slave modport is the decoder itself.
interface fuec_12_8_decoder_interface_if #(
  parameter int CNT_W = 16
);
  logic             valid_in;
  logic [7:0]       data;
  logic [3:0]       redundancy;
  logic             valid_out;
  logic [7:0]       data_dec;
  logic [7:0]       pos_error;
  logic [3:0]       syndrome;
  logic             no_error;
  logic             corrected;
  logic             uncorrectable;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;

  modport master (
    output valid_in, data, redundancy,
    input  valid_out, data_dec, pos_error, syndrome,
    input  no_error, corrected, uncorrectable, corr_count, uncorr_count
  );

  modport slave (
    input  valid_in, data, redundancy,
    output valid_out, data_dec, pos_error, syndrome,
    output no_error, corrected, uncorrectable, corr_count, uncorr_count
  );
endinterface

// File: rtl/fuec_12_8_decoder_interface.sv
// Registered single-error-correcting decoder for the FUEC (12,8) code.
// Codeword layout is {redundancy[3:0], data[7:0]}.
// All results appear one cycle after valid_in.
// Results hold while no word is presented.
// Corrected and uncorrectable words are tallied in saturating counters.
module fuec_12_8_decoder_interface #(
  parameter int CNT_W = 16
) (
  input logic                         clk,
  input logic                         rst,
  fuec_12_8_decoder_interface_if.slave bus
);

  // H matrix columns for data bits d0..d7, packed 4 bits per column (s3..s0).
  localparam logic [31:0] H_COLS = {4'b1011, 4'b0111, 4'b1100, 4'b1010,
                                    4'b1001, 4'b0110, 4'b0101, 4'b0011};

  logic [3:0]       p_calc;
  logic [3:0]       syn_c;
  logic [7:0]       col_hit;
  logic             par_hit;
  logic             is_zero;
  logic             is_corr;
  logic             is_unc;

  logic             valid_reg;
  logic [7:0]       data_dec_reg;
  logic [7:0]       pos_reg;
  logic [3:0]       syn_reg;
  logic             no_err_reg;
  logic             corr_reg;
  logic             unc_reg;
  logic [CNT_W-1:0] corr_cnt_reg;
  logic [CNT_W-1:0] unc_cnt_reg;

  // Recompute the parity bits from the received data bits.
  always_comb begin
    p_calc[0] = bus.data[0] ^ bus.data[1] ^ bus.data[3] ^ bus.data[6] ^ bus.data[7];
    p_calc[1] = bus.data[0] ^ bus.data[2] ^ bus.data[4] ^ bus.data[6] ^ bus.data[7];
    p_calc[2] = bus.data[1] ^ bus.data[2] ^ bus.data[5] ^ bus.data[6];
    p_calc[3] = bus.data[3] ^ bus.data[4] ^ bus.data[5] ^ bus.data[7];
  end

  assign syn_c = p_calc ^ bus.redundancy;

  // One comparator per data column.
  // A hit both names the bit to flip and gives the one-hot position.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_col
      assign col_hit[gi] = (syn_c == H_COLS[gi*4 +: 4]);
    end
  endgenerate

  // Any single-bit syndrome means a parity bit was hit.
  // In that case the data is left untouched.
  assign par_hit = (syn_c == 4'b0001) || (syn_c == 4'b0010) ||
                   (syn_c == 4'b0100) || (syn_c == 4'b1000);
  assign is_zero = (syn_c == 4'b0000);
  assign is_corr = (|col_hit) || par_hit;
  assign is_unc  = !is_zero && !is_corr;

  // Capture decode results for each valid word.
  // Results hold when idle.
  // Counters advance only on valid words and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      data_dec_reg <= '0;
      pos_reg      <= '0;
      syn_reg      <= '0;
      no_err_reg   <= 1'b1;
      corr_reg     <= 1'b0;
      unc_reg      <= 1'b0;
      corr_cnt_reg <= '0;
      unc_cnt_reg  <= '0;
    end else begin
      valid_reg <= bus.valid_in;
      if (bus.valid_in) begin
        data_dec_reg <= bus.data ^ col_hit;
        pos_reg      <= col_hit;
        syn_reg      <= syn_c;
        no_err_reg   <= is_zero;
        corr_reg     <= is_corr;
        unc_reg      <= is_unc;
        if (is_corr && (corr_cnt_reg != {CNT_W{1'b1}})) begin
          corr_cnt_reg <= corr_cnt_reg + CNT_W'(1);
        end
        if (is_unc && (unc_cnt_reg != {CNT_W{1'b1}})) begin
          unc_cnt_reg <= unc_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.valid_out     = valid_reg;
  assign bus.data_dec      = data_dec_reg;
  assign bus.pos_error     = pos_reg;
  assign bus.syndrome      = syn_reg;
  assign bus.no_error      = no_err_reg;
  assign bus.corrected     = corr_reg;
  assign bus.uncorrectable = unc_reg;
  assign bus.corr_count    = corr_cnt_reg;
  assign bus.uncorr_count  = unc_cnt_reg;

endmodule

// File: tb/tb_fuec_12_8_decoder_interface.sv
// Self-checking bench for fuec_12_8_decoder_interface.
// The reference model treats the word as a 12-bit codeword.
// It builds the syndrome as the XOR of the H columns of all set bits.
// It classifies the syndrome by searching the full 12-column table.
module tb_fuec_12_8_decoder_interface;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fuec_12_8_decoder_interface_if #(.CNT_W(CNT_W)) bus ();

  fuec_12_8_decoder_interface #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Codeword positions 0..7 are data bits; positions 8..11 are parity bits.
  int h_col [12] = '{3, 5, 6, 9, 10, 12, 7, 11, 1, 2, 4, 8};

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Expected outputs.
  int e_valid, e_data, e_pos, e_syn, e_noerr, e_corr, e_unc, e_cc, e_uc;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  function automatic logic [3:0] encode(input logic [7:0] d);
    int s = 0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) s ^= h_col[i];
    end
    return s[3:0];
  endfunction

  task automatic model_word(input logic [7:0] d, input logic [3:0] r);
    logic [11:0] cw;
    int s;
    int k;
    cw = {r, d};
    s  = 0;
    k  = -1;
    for (int i = 0; i < 12; i++) begin
      if (cw[i]) s ^= h_col[i];
    end
    for (int i = 0; i < 12; i++) begin
      if (h_col[i] == s) k = i;
    end
    e_valid = 1;
    e_syn   = s;
    e_data  = d;
    e_pos   = 0;
    e_noerr = (s == 0);
    e_corr  = 0;
    e_unc   = 0;
    if (s != 0) begin
      if (k >= 0) begin
        e_corr = 1;
        if (k < 8) begin
          e_data = d ^ (1 << k);
          e_pos  = 1 << k;
        end
        if (e_cc < CMAX) e_cc++;
      end else begin
        e_unc = 1;
        if (e_uc < CMAX) e_uc++;
      end
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_data = 0; e_pos = 0; e_syn = 0;
    e_noerr = 1; e_corr = 0; e_unc = 0; e_cc = 0; e_uc = 0;
  endtask

  task automatic compare_all();
    check("valid_out",     int'(bus.valid_out),     e_valid);
    check("data_dec",      int'(bus.data_dec),      e_data);
    check("pos_error",     int'(bus.pos_error),     e_pos);
    check("syndrome",      int'(bus.syndrome),      e_syn);
    check("no_error",      int'(bus.no_error),      e_noerr);
    check("corrected",     int'(bus.corrected),     e_corr);
    check("uncorrectable", int'(bus.uncorrectable), e_unc);
    check("corr_count",    int'(bus.corr_count),    e_cc);
    check("uncorr_count",  int'(bus.uncorr_count),  e_uc);
  endtask

  // One clock with the given inputs.
  // Outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] r, input logic do_rst);
    rst            = do_rst;
    bus.valid_in   = v;
    bus.data       = d;
    bus.redundancy = r;
    @(posedge clk);
    if (do_rst) model_reset();
    else if (v) model_word(d, r);
    else e_valid = 0;
    #1;
    n_txn++;
    compare_all();
    $display("txn %0d rst=%0b v=%0b d=%02h r=%01h -> dec=%02h pos=%02h syn=%01h ne/c/u=%0b%0b%0b cc=%0d uc=%0d",
             n_txn, do_rst, v, d, r, bus.data_dec, bus.pos_error, bus.syndrome,
             bus.no_error, bus.corrected, bus.uncorrectable, bus.corr_count, bus.uncorr_count);
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] r;
    logic [11:0] cw;
    int nflip;

    bus.valid_in   = 1'b0;
    bus.data       = '0;
    bus.redundancy = '0;
    model_reset();

    // Reset with a word offered at the same time; reset must win.
    step(1'b1, 8'hAC, 4'h0, 1'b1);
    step(1'b1, 8'hAC, 4'h0, 1'b1);

    // Clean codeword from the reference vector.
    step(1'b1, 8'hAC, 4'b1000, 1'b0);
    check("clean_dec_const", int'(bus.data_dec), 'hAC);
    check("clean_syn_const", int'(bus.syndrome), 0);

    // Single data-bit flip on bit 0.
    step(1'b1, 8'hAD, 4'b1000, 1'b0);
    check("flip0_syn_const", int'(bus.syndrome), 'b0011);
    check("flip0_cc_const",  int'(bus.corr_count), 1);

    // Sweep data-bit flips, one per cycle.
    for (int i = 0; i < 8; i++) begin
      d = 8'hAC ^ (8'h01 << i);
      step(1'b1, d, 4'b1000, 1'b0);
      check("sweep_pos_const", int'(bus.pos_error), 1 << i);
    end

    // Parity bit 11 flipped.
    step(1'b1, 8'hAC, 4'b0000, 1'b0);
    check("p11_syn_const", int'(bus.syndrome), 'b1000);

    // Bits 6 and 11 flipped: syndrome 1111, uncorrectable.
    step(1'b1, 8'hEC, 4'b0000, 1'b0);
    check("dbl_syn_const", int'(bus.syndrome), 'b1111);
    check("dbl_dec_const", int'(bus.data_dec), 'hEC);

    // Idle cycles: results hold, valid_out drops.
    step(1'b0, 8'h55, 4'h3, 1'b0);
    step(1'b0, 8'h12, 4'hF, 1'b0);

    // Random words with 0, 1 or 2 flipped codeword bits.
    for (int n = 0; n < 200; n++) begin
      d     = 8'($urandom);
      cw    = {encode(d), d};
      nflip = $urandom_range(0, 2);
      for (int f = 0; f < nflip; f++) cw[$urandom_range(0, 11)] ^= 1'b1;
      step(($urandom_range(0, 4) != 0), cw[7:0], cw[11:8], 1'b0);
    end

    // Reset in the middle of back-to-back valid words.
    step(1'b1, 8'h0F, 4'h0, 1'b0);
    step(1'b1, 8'hF0, 4'h0, 1'b0);
    step(1'b1, 8'h3C, 4'h0, 1'b1);
    check("midrst_cc_const", int'(bus.corr_count), 0);
    step(1'b1, 8'hAC, 4'b1000, 1'b0);

    // Saturation of both counters; 1101/1110/1111 syndromes are uncorrectable.
    for (int n = 0; n < CMAX + 20; n++) begin
      d = 8'($urandom);
      case (n % 3)
        0:       r = encode(d) ^ 4'b1101;
        1:       r = encode(d) ^ 4'b1110;
        default: r = encode(d) ^ 4'b1111;
      endcase
      step(1'b1, d, r, 1'b0);
      d = 8'($urandom);
      r = encode(d) ^ 4'(h_col[$urandom_range(0, 11)]);
      step(1'b1, d, r, 1'b0);
    end
    check("sat_uc_const", int'(bus.uncorr_count), CMAX);
    check("sat_cc_const", int'(bus.corr_count), CMAX);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
